// File: rtl/proj_frag_assembler.sv
// Reassembles FRAG_PART-bit slices, sent LSB-first, into FRAG_LEN-bit fragments with their window index.
// Each fragment is presented once on a valid/ready output, and the last fragment of every index set is flagged.
module proj_frag_assembler #(
    parameter int KMER_LEN          = 4,
    parameter int FRAG_LEN          = 8,
    parameter int BASE_LEN          = 2,
    parameter int INDICES_COUNT     = 3,
    parameter int INDICE_LEN        = 5,
    parameter int FRAG_PART         = 2,
    parameter int SIGNED_INDICE_LEN = INDICE_LEN + 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SIGNED_INDICE_LEN-1:0] in_index,
    input  logic [FRAG_PART-1:0]         in_gfm,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [FRAG_LEN-1:0]          out_fragment,
    output logic [SIGNED_INDICE_LEN-1:0] out_index,
    output logic [INDICE_LEN-1:0]        out_kmer_index,
    output logic                         out_below_zero,
    output logic                         out_last,
    output logic                         err_index_mismatch
);
    localparam int PARTS  = FRAG_LEN / FRAG_PART;
    localparam int PCW    = (PARTS > 1) ? $clog2(PARTS) : 1;
    localparam int FCW    = (INDICES_COUNT > 1) ? $clog2(INDICES_COUNT) : 1;
    localparam int OFFSET = (FRAG_LEN - KMER_LEN) / 2;

    if (FRAG_LEN % FRAG_PART != 0 || BASE_LEN < 1) begin : g_bad_params
        $error("proj_frag_assembler: FRAG_LEN must be a multiple of FRAG_PART");
    end

    logic [PCW-1:0]               part_cnt;
    logic [FRAG_LEN-1:0]          asm_reg;
    logic [FRAG_LEN-1:0]          merged;
    logic [SIGNED_INDICE_LEN-1:0] idx_reg;
    logic [SIGNED_INDICE_LEN-1:0] frag_idx;
    logic [FCW-1:0]               frag_cnt;
    logic                         last_part;
    logic                         accept;
    logic                         drain;

    assign last_part = (part_cnt == PCW'(PARTS - 1));
    // Only the closing slice needs the output register, so only it can stall.
    assign in_ready  = rst_n && !(last_part && out_valid && !out_ready);
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;
    assign frag_idx  = (PARTS == 1) ? in_index : idx_reg;

    always_comb begin
        merged = asm_reg;
        for (int p = 0; p < PARTS; p++) begin
            if (part_cnt == PCW'(p)) merged[p*FRAG_PART +: FRAG_PART] = in_gfm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            part_cnt           <= '0;
            asm_reg            <= '0;
            idx_reg            <= '0;
            frag_cnt           <= '0;
            out_valid          <= 1'b0;
            out_fragment       <= '0;
            out_index          <= '0;
            out_last           <= 1'b0;
            err_index_mismatch <= 1'b0;
        end else begin
            if (accept) begin
                asm_reg  <= merged;
                part_cnt <= last_part ? '0 : part_cnt + PCW'(1);
                if (part_cnt == '0) idx_reg <= in_index;
                else if (in_index != idx_reg) err_index_mismatch <= 1'b1;
            end
            // A completing fragment overwrites the output even while it drains: no bubble.
            if (accept && last_part) begin
                out_valid    <= 1'b1;
                out_fragment <= merged;
                out_index    <= frag_idx;
                out_last     <= (frag_cnt == FCW'(INDICES_COUNT - 1));
                frag_cnt     <= (frag_cnt == FCW'(INDICES_COUNT - 1)) ? '0 : frag_cnt + FCW'(1);
            end else if (drain) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_kmer_index = out_index[INDICE_LEN-1:0] + INDICE_LEN'(OFFSET);
    assign out_below_zero = out_index[SIGNED_INDICE_LEN-1];

endmodule

// File: tb/tb_proj_frag_assembler.sv
// Randomized and directed bench for proj_frag_assembler against a queue-based fragment model.
module tb_proj_frag_assembler;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [5:0] in_index = '0;
    logic [1:0] in_gfm = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_fragment;
    logic [5:0] out_index;
    logic [4:0] out_kmer_index;
    logic       out_below_zero;
    logic       out_last;
    logic       err_index_mismatch;

    proj_frag_assembler dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_index(in_index), .in_gfm(in_gfm), .out_valid(out_valid), .out_ready(out_ready),
        .out_fragment(out_fragment), .out_index(out_index), .out_kmer_index(out_kmer_index),
        .out_below_zero(out_below_zero), .out_last(out_last), .err_index_mismatch(err_index_mismatch)
    );

    always #5 clk = ~clk;

    typedef struct { int frag; int idx; bit last; } frag_t;
    frag_t q[$];
    int    drain_log[$];
    int    m_part, m_idx, m_val, m_fcnt, cyc;
    bit    m_err;
    int    checks = 0;
    int    failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        drain_log.delete();
        m_part = 0; m_idx = 0; m_val = 0; m_fcnt = 0; m_err = 0;
    endtask

    // A fragment is the concatenation of its four slices, first slice in the low bits.
    task automatic model_slice(input int idx, input int g);
        frag_t f;
        if (m_part == 0) begin
            m_idx = idx;
            m_val = 0;
        end else if (idx != m_idx) begin
            m_err = 1;
        end
        m_val = m_val + (g << (2 * m_part));
        m_part++;
        if (m_part == 4) begin
            f.frag = m_val; f.idx = m_idx; f.last = (m_fcnt == 2);
            q.push_back(f);
            m_fcnt = (m_fcnt + 1) % 3;
            m_part = 0;
        end
    endtask

    task automatic compare();
        chk("out_valid", int'(out_valid), int'(q.size() != 0));
        chk("err_index_mismatch", int'(err_index_mismatch), int'(m_err));
        if (q.size() != 0) begin
            chk("out_fragment", int'(out_fragment), q[0].frag);
            chk("out_index", int'($signed(out_index)), q[0].idx);
            chk("out_kmer_index", int'(out_kmer_index), ((q[0].idx + 2) % 32 + 32) % 32);
            chk("out_below_zero", int'(out_below_zero), int'(q[0].idx < 0));
            chk("out_last", int'(out_last), int'(q[0].last));
        end
    endtask

    // One clock: drive at the falling edge, resolve handshakes just before the rising edge, check after it.
    task automatic step(input logic iv, input int idx, input int g, input logic ordy, output logic acc);
        logic drn;
        bit   exp_rdy;
        in_valid = iv; in_index = 6'(idx); in_gfm = 2'(g); out_ready = ordy;
        #1;
        exp_rdy = rst_n && !(m_part == 3 && q.size() != 0 && !ordy);
        chk("in_ready", int'(in_ready), int'(exp_rdy));
        acc = in_valid && in_ready;
        drn = out_valid && out_ready;
        @(posedge clk);
        if (!rst_n) model_reset();
        else begin
            if (drn) begin
                void'(q.pop_front());
                drain_log.push_back(cyc);
            end
            if (acc) model_slice(idx, g);
        end
        cyc++;
        @(negedge clk);
        compare();
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b1, a);
    endtask

    task automatic do_reset();
        logic a;
        rst_n = 1'b0;
        step(1'b1, 0, 1, 1'b1, a);
        step(1'b1, 0, 2, 1'b0, a);
        chk("reset_out_valid", int'(out_valid), 0);
        chk("reset_err", int'(err_index_mismatch), 0);
        rst_n = 1'b1;
    endtask

    task automatic send_slice(input int idx, input int g, input logic ordy);
        logic a;
        for (int t = 0; t < 50; t++) begin
            step(1'b1, idx, g, ordy, a);
            if (a) return;
        end
        chk("send_timeout", 0, 1);
    endtask

    task automatic send_frag(input int idx, input int val, input logic ordy);
        for (int k = 0; k < 4; k++) send_slice(idx, (val >> (2 * k)) & 3, ordy);
    endtask

    initial begin
        logic a;
        int   ridx;
        model_reset();
        cyc = 0;

        // Basic assembly and latency
        do_reset();
        send_slice(-2, 1, 1'b1);
        send_slice(-2, 2, 1'b1);
        send_slice(-2, 3, 1'b1);
        chk("t1_not_yet_valid", int'(out_valid), 0);
        send_slice(-2, 0, 1'b1);
        chk("t1_model_frag", q[0].frag, 'h39);
        chk("t1_valid", int'(out_valid), 1);
        chk("t1_frag", int'(out_fragment), 'h39);
        chk("t1_index", int'($signed(out_index)), -2);
        chk("t1_kmer", int'(out_kmer_index), 0);
        chk("t1_below", int'(out_below_zero), 1);

        // Index offset and set boundary
        do_reset();
        send_frag(3, 'h12, 1'b1);
        chk("t2_kmer0", int'(out_kmer_index), 5);
        chk("t2_last0", int'(out_last), 0);
        send_frag(7, 'h34, 1'b1);
        chk("t2_kmer1", int'(out_kmer_index), 9);
        chk("t2_last1", int'(out_last), 0);
        send_frag(20, 'h56, 1'b1);
        chk("t2_kmer2", int'(out_kmer_index), 22);
        chk("t2_last2", int'(out_last), 1);
        send_frag(-5, 'h78, 1'b1);
        chk("t2_kmer3", int'(out_kmer_index), 29);
        chk("t2_last3", int'(out_last), 0);

        // Backpressure on the closing slice
        do_reset();
        send_frag(1, 'hA5, 1'b0);
        chk("t3_first", int'(out_fragment), 'hA5);
        for (int k = 0; k < 3; k++) send_slice(2, ('h5A >> (2 * k)) & 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 2, 1, 1'b0, a);
            chk("t3_stalled", int'(a), 0);
            chk("t3_held", int'(out_fragment), 'hA5);
        end
        send_slice(2, 1, 1'b1);
        chk("t3_second", int'(out_fragment), 'h5A);
        chk("t3_second_idx", int'($signed(out_index)), 2);
        idle(1);
        chk("t3_empty", int'(out_valid), 0);
        chk("t3_drained", drain_log.size(), 2);

        // Sticky index mismatch
        do_reset();
        send_slice(4, 1, 1'b1);
        send_slice(4, 1, 1'b1);
        send_slice(5, 1, 1'b1);
        send_slice(4, 1, 1'b1);
        chk("t4_err", int'(err_index_mismatch), 1);
        chk("t4_index", int'($signed(out_index)), 4);
        send_frag(9, 'hC3, 1'b1);
        idle(2);
        chk("t4_err_sticky", int'(err_index_mismatch), 1);
        do_reset();
        chk("t4_err_cleared", int'(err_index_mismatch), 0);

        // Reset mid-fragment
        send_slice(8, 3, 1'b1);
        send_slice(8, 3, 1'b1);
        do_reset();
        send_frag(10, 'h81, 1'b1);
        chk("t5_frag", int'(out_fragment), 'h81);
        chk("t5_last0", int'(out_last), 0);
        send_frag(11, 'h82, 1'b1);
        send_frag(12, 'h83, 1'b1);
        chk("t5_last2", int'(out_last), 1);

        // Full throughput
        do_reset();
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 6, int'($urandom_range(0, 3)), 1'b1, a);
            chk("t6_accept", int'(a), 1);
        end
        chk("t6_last", int'(out_last), 1);
        idle(1);
        chk("t6_count", drain_log.size(), 3);
        if (drain_log.size() == 3) begin
            chk("t6_gap0", drain_log[1] - drain_log[0], 4);
            chk("t6_gap1", drain_log[2] - drain_log[1], 4);
        end

        // Random traffic with random backpressure
        do_reset();
        ridx = 0;
        for (int i = 0; i < 600; i++) begin
            if (m_part == 0) ridx = int'($urandom_range(0, 63)) - 32;
            step(($urandom_range(0, 9) < 7), ridx, int'($urandom_range(0, 3)),
                 ($urandom_range(0, 9) < 6), a);
        end
        idle(3);
        chk("rand_drained", int'(out_valid), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/proj_frag_assembler.md
Name: proj_frag_assembler

Overview:
Receiving end of the fragment-part stream produced by the project's extender. Collects FRAG_PART-bit GFM slices LSB-first, reassembles each FRAG_LEN-bit fragment with its signed window index, and recovers the original k-mer index. Presents one fragment per valid/ready transfer to the downstream MinHash stage. Flags a fragment set boundary every INDICES_COUNT fragments.

Parameters:
KMER_LEN, 4, k-mer length used for the index offset
FRAG_LEN, 8, fragment width in bits
BASE_LEN, proj_pkg::BASE_LEN, bits per base (informational, not used in datapath)
INDICES_COUNT, 3, fragments per k-mer index set
INDICE_LEN, 5, unsigned k-mer index width
FRAG_PART, 2, bits per incoming slice; FRAG_LEN must be a multiple of FRAG_PART
SIGNED_INDICE_LEN, INDICE_LEN+1, signed window index width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_valid  in  1  slice valid
in_ready  out  1  slice accepted when in_valid && in_ready
in_index  in  SIGNED_INDICE_LEN  signed window index of the slice
in_gfm  in  FRAG_PART  fragment slice
out_valid  out  1  fragment valid
out_ready  in  1  downstream accepts
out_fragment  out  FRAG_LEN  reassembled fragment
out_index  out  SIGNED_INDICE_LEN  signed window index (first slice's)
out_kmer_index  out  INDICE_LEN  out_index + (FRAG_LEN-KMER_LEN)/2, truncated
out_below_zero  out  1  out_index sign bit
out_last  out  1  last fragment of an INDICES_COUNT set
err_index_mismatch  out  1  sticky error: slice index differed within a fragment

Behaviour:
- Derived values: PARTS = FRAG_LEN/FRAG_PART. OFFSET = (FRAG_LEN-KMER_LEN)/2.
- State: part_cnt (0..PARTS-1), asm_reg (FRAG_LEN), idx_reg, frag_cnt (0..INDICES_COUNT-1), output register and out_valid, error flag.
- Reset: all state and outputs 0. in_ready is 0 while rst_n is low.
- Accept: slice k (k = part_cnt) is written to asm_reg[FRAG_PART*k +: FRAG_PART].
  - part_cnt increments and wraps to 0 after PARTS-1.
  - On k=0, idx_reg <= in_index.
- Index check: for k>0, if in_index != idx_reg, set err_index_mismatch.
  - The slice is still accepted.
  - The fragment keeps idx_reg.
  - The error clears only on reset.
- Completion: the final slice (k=PARTS-1) loads the output register directly in the same cycle.
  - out_fragment = asm_reg with the current slice merged in.
  - out_index = idx_reg, or in_index when PARTS==1.
  - out_valid = 1 from the next cycle. Latency is 1 cycle after the final slice is accepted.
- in_ready = rst_n && !(part_cnt==PARTS-1 && out_valid && !out_ready). Only the final slice stalls. Non-final slices are always accepted.
- Simultaneous events: a drain (out_valid && out_ready) in the same cycle as the final slice loads the new fragment. out_valid stays 1. No bubble.
- Drain without a new fragment: out_valid <= 0.
- Output stability: while out_valid && !out_ready, all out_* fields are held stable.
- out_kmer_index = (out_index + OFFSET) mod 2^INDICE_LEN. Computed combinationally from the output register.
- out_below_zero = out_index[SIGNED_INDICE_LEN-1].
- out_last: frag_cnt advances on each fragment load into the output register and wraps after INDICES_COUNT-1. out_last is registered with the fragment and is 1 when that fragment's count is INDICES_COUNT-1.
- Reset mid-fragment: the partial fragment is discarded, part_cnt=0, frag_cnt=0, the pending output is dropped, and the error is cleared.
- Throughput: one fragment per PARTS cycles when out_ready is held high.

Test Plan:
1. Slices 01,10,11,00 with in_index=-2, out_ready=1 -> out_fragment=8'h39, out_index=-2, out_kmer_index=0, out_below_zero=1, out_valid high the cycle after the 4th slice.
2. Three fragments at indices 3,7,20 -> out_kmer_index 5,9,22; out_last=1 only on the third; a fourth fragment has out_last=0.
3. out_ready=0, stream two fragments -> the second fragment's 4th slice is stalled (in_ready=0) and the first is held stable; out_ready=1 then gives both in order with no loss or duplication.
4. Slice index changes 4->5 at slice 2 -> err_index_mismatch=1, fragment emitted with out_index=4, error stays set over later clean fragments until rst_n=0.
5. Reset asserted after 2 slices -> out_valid=0, err=0, in_ready=0 during reset; the next 4 slices form a clean fragment and out_last counting restarts.
6. Continuous in_valid=1 and out_ready=1 for 12 slices -> in_ready constantly 1, three fragments spaced 4 cycles apart, out_last on the third.
